// File: rtl/apb2axi_cpl_arbiter_if.sv
// Completion-arbiter bus: read/write completion producers in, completion FIFO push port out,
// plus per-source queue occupancy.
interface apb2axi_cpl_arbiter_if #(
  parameter int TAG_W        = 4,
  parameter int COMPLETION_W = TAG_W + 12,
  parameter int QDEPTH       = 2
);
  localparam int LVL_W = $clog2(QDEPTH + 1);

  logic                    rd_cpl_valid;
  logic [COMPLETION_W-1:0] rd_cpl_data;
  logic                    rd_cpl_ready;
  logic                    wr_cpl_valid;
  logic [COMPLETION_W-1:0] wr_cpl_data;
  logic                    wr_cpl_ready;
  logic                    cpl_push_valid;
  logic [COMPLETION_W-1:0] cpl_push_data;
  logic                    cpl_push_ready;
  logic [LVL_W-1:0]        rd_q_level;
  logic [LVL_W-1:0]        wr_q_level;

  modport master (
    output rd_cpl_valid, rd_cpl_data, wr_cpl_valid, wr_cpl_data, cpl_push_ready,
    input  rd_cpl_ready, wr_cpl_ready, cpl_push_valid, cpl_push_data, rd_q_level, wr_q_level
  );

  modport slave (
    input  rd_cpl_valid, rd_cpl_data, wr_cpl_valid, wr_cpl_data, cpl_push_ready,
    output rd_cpl_ready, wr_cpl_ready, cpl_push_valid, cpl_push_data, rd_q_level, wr_q_level
  );
endinterface

// File: rtl/apb2axi_cpl_arbiter.sv
// Merges read/write completion records into one FIFO push port; QDEPTH-deep queue per source.
// Latency: accepted at edge N, visible at the output after edge N+1; one record/cycle sustained.
// Backpressure: output held while not ready, queues fill, src_ready drops at full. APB2AXI_CPL_WR_PRIO_EN: writes win ties.
module apb2axi_cpl_arbiter #(
  parameter int TAG_W        = 4,
  parameter int COMPLETION_W = TAG_W + 12,
  parameter int QDEPTH       = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  apb2axi_cpl_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int LVL_W = $clog2(QDEPTH + 1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(QDEPTH);

  typedef logic [COMPLETION_W-1:0] cpl_t;

  cpl_t             rq_mem [QDEPTH];
  cpl_t             wq_mem [QDEPTH];
  logic [PTR_W-1:0] rq_wptr, rq_rptr, wq_wptr, wq_rptr;
  logic [LVL_W-1:0] rq_lvl, wq_lvl;
  logic             out_vld;
  cpl_t             out_dat;

  logic rq_push, wq_push, rq_pop, wq_pop;
  logic rq_ne, wq_ne, can_load;

  // Ready looks only at the registered level: a same-cycle pop never frees a slot early.
  assign bus.rd_cpl_ready   = (rq_lvl != FULL);
  assign bus.wr_cpl_ready   = (wq_lvl != FULL);
  assign bus.rd_q_level     = rq_lvl;
  assign bus.wr_q_level     = wq_lvl;
  assign bus.cpl_push_valid = out_vld;
  assign bus.cpl_push_data  = out_dat;

  assign rq_push  = bus.rd_cpl_valid && bus.rd_cpl_ready;
  assign wq_push  = bus.wr_cpl_valid && bus.wr_cpl_ready;
  assign rq_ne    = (rq_lvl != '0);
  assign wq_ne    = (wq_lvl != '0);
  assign can_load = !out_vld || bus.cpl_push_ready;

`ifdef APB2AXI_CPL_WR_PRIO_EN
  always_comb begin
    wq_pop = can_load && wq_ne;
    rq_pop = can_load && rq_ne && !wq_ne;
  end
`else
  typedef enum logic {GNT_READ, GNT_WRITE} gnt_e;
  gnt_e last_grant;

  always_comb begin
    rq_pop = 1'b0;
    wq_pop = 1'b0;
    if (can_load) begin
      if (rq_ne && wq_ne) begin
        rq_pop = (last_grant == GNT_WRITE);
        wq_pop = (last_grant == GNT_READ);
      end else begin
        rq_pop = rq_ne;
        wq_pop = wq_ne;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)    last_grant <= GNT_WRITE;
    else if (rq_pop) last_grant <= GNT_READ;
    else if (wq_pop) last_grant <= GNT_WRITE;
  end
`endif

  // Storage needs no reset: only slots between the reset pointers are ever read.
  always_ff @(posedge aclk) begin
    if (rq_push) rq_mem[rq_wptr] <= bus.rd_cpl_data;
    if (wq_push) wq_mem[wq_wptr] <= bus.wr_cpl_data;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rq_wptr <= '0;
      rq_rptr <= '0;
      wq_wptr <= '0;
      wq_rptr <= '0;
      rq_lvl  <= '0;
      wq_lvl  <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)  rq_rptr <= rq_rptr + 1'b1;
      if (wq_push) wq_wptr <= wq_wptr + 1'b1;
      if (wq_pop)  wq_rptr <= wq_rptr + 1'b1;
      rq_lvl <= rq_lvl + LVL_W'(rq_push) - LVL_W'(rq_pop);
      wq_lvl <= wq_lvl + LVL_W'(wq_push) - LVL_W'(wq_pop);
      if (can_load) begin
        out_vld <= rq_pop || wq_pop;
        if (rq_pop)      out_dat <= rq_mem[rq_rptr];
        else if (wq_pop) out_dat <= wq_mem[wq_rptr];
      end
    end
  end
endmodule
